uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/byte_fifo.sv | 55 +++++
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types, register offsets and STATUS bit positions for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;
  localparam int unsigned ST_COUNT = 8;

  // Rounded clock-per-bit divider.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Data-memory bus slice seen by the serial device.
interface uart_tx_fifo_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, output we, output re, output addr, output din, input dout);
  modport slave  (input sel, input we, input re, input addr, input din, output dout);
endinterface

// File: rtl/byte_fifo.sv
// Show-ahead synchronous byte FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   din,
  output logic [7:0]                   dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter fed by a small byte FIFO, with a pollable STATUS word.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DEPTH    = 16
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_fifo_if.slave    bus,
  output logic             tx
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  uart_state_e   state, state_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [2:0]    nbit, nbit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt;
  logic          pop_c;
  logic          bit_end;

  logic          wr_data;
  logic          rd_status;
  logic          drop;
  logic          overflow;
  logic [31:0]   status;

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          unused_bits;
  assign unused_bits = &{1'b0, bus.din[31:8], bus.addr[1:0]};

  // Word-offset decode; the low two address bits are ignored.
  assign wr_data   = bus.sel & bus.we & (bus.addr[3:2] == UART_DATA[3:2]);
  assign rd_status = bus.sel & bus.re & (bus.addr[3:2] == UART_STATUS[3:2]);
  assign drop      = wr_data & fifo_full & ~pop_c;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_data),
    .pop   (pop_c),
    .din   (bus.din[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STATUS word assembled from registered state.
  always_comb begin
    status                 = '0;
    status[ST_FULL]        = fifo_full;
    status[ST_EMPTY]       = fifo_empty;
    status[ST_BUSY]        = (state != IDLE);
    status[ST_OVF]         = overflow;
    status[ST_COUNT +: CW] = fifo_count;
  end

  // DATA and unmapped offsets read as zero.
  assign bus.dout = rd_status ? status : 32'h0;

  // Sticky overflow: a drop in the same cycle wins over the read-to-clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (rd_status) begin
      overflow <= 1'b0;
    end
  end

  // Frame state, counters, shift register and line register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bcnt  <= '0;
      nbit  <= '0;
      shreg <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      nbit  <= nbit_nxt;
      shreg <= shreg_nxt;
      tx    <= tx_nxt;
    end
  end

  assign bit_end = (bcnt == BW'(DIV - 1));

  // Next-state: each bit holds the line for DIV cycles; STOP chains straight into the next START.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    nbit_nxt  = nbit;
    shreg_nxt = shreg;
    tx_nxt    = tx;
    pop_c     = 1'b0;

    case (state)
      IDLE: begin
        bcnt_nxt = '0;
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          shreg_nxt = fifo_dout;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          bcnt_nxt  = '0;
          nbit_nxt  = '0;
          tx_nxt    = shreg[0];
          state_nxt = DATA;
        end else begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bcnt_nxt  = '0;
          shreg_nxt = {1'b0, shreg[7:1]};
          if (nbit == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            tx_nxt   = shreg[1];
            nbit_nxt = nbit + 3'd1;
          end
        end else begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bcnt_nxt = '0;
          if (!fifo_empty) begin
            pop_c     = 1'b1;
            shreg_nxt = fifo_dout;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at DIV=10, DEPTH=4.
module tb_uart_tx_fifo;

  localparam int unsigned DIV   = 10;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  logic tx;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_FREQ (1000),
    .BAUD     (100),
    .DEPTH    (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q [$];
  longint      starts_q [$];
  longint      pcnt = 0;
  longint      ncnt = 0;

  always @(posedge clock) pcnt <= pcnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input bit full, input bit empty, input bit busy,
                                     input bit ovf, input int cnt);
    return {21'b0, 3'(cnt), 4'b0, ovf, busy, empty, full};
  endfunction

  // Line monitor: decodes frames mid-bit and pops the scoreboard at each stop bit.
  logic        mon_busy = 1'b0;
  int unsigned mon_off  = 0;
  logic [7:0]  mon_byte = 8'h00;
  always @(negedge clock) begin
    int unsigned k;
    ncnt++;
    if (reset) begin
      mon_busy = 1'b0;
      exp_q.delete();
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_off  = 0;
        starts_q.push_back(ncnt);
      end
    end else begin
      mon_off++;
      if (mon_off % DIV == DIV / 2) begin
        k = mon_off / DIV;
        if (k == 0) begin
          check("start_bit", 32'(tx), 32'd0);
        end else if (k <= 8) begin
          mon_byte[k-1] = tx;
        end else begin
          check("stop_bit", 32'(tx), 32'd1);
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; leaves the bus idle at the next posedge+1.
  task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit acc);
    bus.sel  = 1'b1;
    bus.we   = 1'b1;
    bus.re   = 1'b0;
    bus.addr = a;
    bus.din  = {24'hC3C3C3, d};
    if (acc) exp_q.push_back(d);
    @(posedge clock);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus.sel  = 1'b1;
    bus.re   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    @(negedge clock);
    check(tag, bus.dout, exp);
    @(posedge clock);
    #1;
    bus.sel = 1'b0;
    bus.re  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int     bad, txe, bze, gerr, nst;
    logic   exp_tx;
    logic   exp_bz;
    logic [7:0] d;
    longint e0;

    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    bus.addr = 4'h0;
    bus.din  = 32'h0;
    reset    = 1'b1;
    #12;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_dout_nosel", bus.dout, 32'h0);
    step(3);
    reset = 1'b0;

    // Idle line after reset.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    check("idle_tx_low_cycles", 32'(bad), 32'd0);
    step(1);
    rd(4'h4, st(0, 1, 0, 0, 0), "status_reset");
    rd(4'h0, 32'h0, "data_read_zero");
    rd(4'h8, 32'h0, "offset8_read");
    bus.sel = 1'b0; bus.re = 1'b1; bus.addr = 4'h4;
    @(negedge clock);
    check("dout_nosel", bus.dout, 32'h0);
    step(1);
    bus.re = 1'b0;
    wr(4'h8, 8'hEE, 1'b0);
    rd(4'h4, st(0, 1, 0, 0, 0), "status_ignored_write");

    // Single 0x55 frame, checked cycle by cycle along with busy.
    d = 8'h55;
    wr(4'h0, d, 1'b1);
    bus.sel = 1'b1; bus.re = 1'b1; bus.addr = 4'h4;
    txe = 0; bze = 0;
    for (int i = 0; i <= 101; i++) begin
      @(negedge clock);
      if (i == 0 || i == 101)   exp_tx = 1'b1;
      else if ((i - 1) / 10 == 0) exp_tx = 1'b0;
      else if ((i - 1) / 10 <= 8) exp_tx = d[(i - 1) / 10 - 1];
      else                      exp_tx = 1'b1;
      exp_bz = (i >= 1 && i <= 100);
      if (tx !== exp_tx) txe++;
      if (bus.dout[2] !== exp_bz) bze++;
    end
    bus.sel = 1'b0; bus.re = 1'b0;
    check("frame55_tx_errs", 32'(txe), 32'd0);
    check("frame55_busy_errs", 32'(bze), 32'd0);
    step(1);

    // Two consecutive writes: back-to-back frames; addr[1:0] ignored.
    step(5);
    starts_q.delete();
    wr(4'h2, 8'hA1, 1'b1);
    wr(4'h0, 8'h3C, 1'b1);
    step(220);
    check("b2b_frames", 32'(starts_q.size()), 32'd2);
    if (starts_q.size() >= 2) check("b2b_gap", 32'(starts_q[1] - starts_q[0]), 32'd100);
    rd(4'h4, st(0, 1, 0, 0, 0), "status_drained");

    // Six writes while the first frame starts: 4 queued, 1 dropped.
    starts_q.delete();
    e0 = pcnt;
    wr(4'h0, 8'h11, 1'b1);
    wr(4'h0, 8'h22, 1'b1);
    wr(4'h0, 8'h33, 1'b1);
    wr(4'h0, 8'h44, 1'b1);
    wr(4'h0, 8'h55, 1'b1);
    wr(4'h0, 8'h66, 1'b0);
    rd(4'h4, st(1, 0, 1, 1, 4), "status_overflow");
    rd(4'h4, st(1, 0, 1, 0, 4), "status_ovf_cleared");

    // Push to full FIFO on the STOP->START pop edge.
    repeat (int'(e0 + 101 - pcnt)) @(posedge clock);
    #1;
    wr(4'h0, 8'h77, 1'b1);
    rd(4'h4, st(1, 0, 1, 0, 4), "status_full_pushpop");
    step(520);
    check("stream_frames", 32'(starts_q.size()), 32'd6);
    gerr = 0;
    for (int i = 1; i < starts_q.size(); i++)
      if (starts_q[i] - starts_q[i-1] != 100) gerr++;
    check("stream_gap_errs", 32'(gerr), 32'd0);
    rd(4'h4, st(0, 1, 0, 0, 0), "status_after_stream");
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Reset 35 cycles into a frame aborts it and discards the queue.
    e0 = pcnt;
    wr(4'h0, 8'h00, 1'b1);
    wr(4'h0, 8'h5A, 1'b1);
    repeat (int'(e0 + 37 - pcnt)) @(posedge clock);
    #1;
    check("pre_reset_tx", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    check("reset_async_tx", 32'(tx), 32'd1);
    step(3);
    reset = 1'b0;
    nst = starts_q.size();
    rd(4'h4, st(0, 1, 0, 0, 0), "status_after_abort");
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    check("tx_low_after_abort", 32'(bad), 32'd0);
    check("starts_after_abort", 32'(starts_q.size()), 32'(nst));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
